// File: rtl/mem_sram_bridge_if.sv
// SRAM-like data bus between the MEM-stage bridge (master) and the memory side (slave).
interface mem_sram_bridge_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                req;
  logic                wr;
  logic [DATA_W/8-1:0] select;
  logic [2:0]          size;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic                addr_ok;
  logic                data_ok;
  logic [DATA_W-1:0]   rdata;

  modport master (
    output req, wr, select, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, select, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/mem_sram_bridge.sv
// MEM stage to SRAM-like bus bridge: one request per enable episode, drops responses of
// flushed requests, aligns and extends load data for write-back.
module mem_sram_bridge #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                enable,
  input  logic                we,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_data_i,
  input  logic [DATA_W/8-1:0] mem_sel_i,
  input  logic [2:0]          mem_size_i,
  input  logic                mem_signed_i,
  output logic                mem_write_finish,
  output logic                mem_read_finish,
  output logic [DATA_W-1:0]   mem_data_o,
  mem_sram_bridge_if.master   bus
);

  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int CNT_W = $clog2(MAX_OUTST);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTST - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, FIN} state_t;

  state_t           state;
  logic [CNT_W-1:0] drop_cnt;
  logic             we_q;
  logic [OFF_W-1:0] off_q;
  logic [2:0]       size_q;
  logic             sgn_q;
  logic             full;
  logic             drop_rsp;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] ext;
  logic             top;
  int unsigned      keep;

  assign bus.wr     = we;
  assign bus.select = mem_sel_i;
  assign bus.size   = mem_size_i;
  assign bus.addr   = mem_addr_i;
  assign bus.wdata  = mem_data_i;

  assign full     = (drop_cnt == FULL_CNT);
  assign drop_rsp = bus.data_ok && (drop_cnt != '0);

  // Sizes at or above the bus width keep every bit, so signedness has no effect there.
  always_comb begin
    shifted = bus.rdata >> {off_q, 3'b000};
    keep    = 32'd8 << size_q;
    top     = 1'b0;
    ext     = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (i + 1 == keep) top = shifted[i];
    end
    for (int unsigned i = 0; i < DATA_W; i++) begin
      ext[i] = (i < keep) ? shifted[i] : (sgn_q & top);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= IDLE;
      drop_cnt         <= '0;
      bus.req          <= 1'b0;
      mem_write_finish <= 1'b0;
      mem_read_finish  <= 1'b0;
      mem_data_o       <= '0;
      we_q             <= 1'b0;
      off_q            <= '0;
      size_q           <= '0;
      sgn_q            <= 1'b0;
    end else begin
      mem_write_finish <= 1'b0;
      mem_read_finish  <= 1'b0;
      case (state)
        IDLE: begin
          if (drop_rsp) drop_cnt <= drop_cnt - 1'b1;
          if (enable && !flush && !full) begin
            state   <= ADDR;
            bus.req <= 1'b1;
          end
        end
        ADDR: begin
          // An accepted-then-flushed request and a returning dropped response net out.
          if (flush) begin
            state   <= IDLE;
            bus.req <= 1'b0;
            if (bus.addr_ok && !drop_rsp)      drop_cnt <= drop_cnt + 1'b1;
            else if (!bus.addr_ok && drop_rsp) drop_cnt <= drop_cnt - 1'b1;
          end else begin
            if (drop_rsp) drop_cnt <= drop_cnt - 1'b1;
            if (bus.addr_ok) begin
              state   <= DATA;
              bus.req <= 1'b0;
              we_q    <= we;
              off_q   <= mem_addr_i[OFF_W-1:0];
              size_q  <= mem_size_i;
              sgn_q   <= mem_signed_i;
            end
          end
        end
        DATA: begin
          if (drop_rsp) begin
            if (flush) state <= IDLE;
            else       drop_cnt <= drop_cnt - 1'b1;
          end else if (flush) begin
            state <= IDLE;
            if (!bus.data_ok) drop_cnt <= drop_cnt + 1'b1;
          end else if (bus.data_ok) begin
            state <= FIN;
            if (we_q) begin
              mem_write_finish <= 1'b1;
            end else begin
              mem_read_finish <= 1'b1;
              mem_data_o      <= ext;
            end
          end
        end
        FIN: begin
          if (drop_rsp) drop_cnt <= drop_cnt - 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(bus.data_ok && drop_cnt == '0 && state != DATA))
        else $error("mem_sram_bridge: data_ok with no transaction outstanding");
    end
  end

endmodule

// File: tb/tb_mem_sram_bridge.sv
// Directed bench for mem_sram_bridge: loads/stores, extension, flush drop tracking, reset.
module tb_mem_sram_bridge;
  logic        clk = 1'b0;
  logic        rst, flush, enable, we;
  logic        flush2, enable2;
  logic [31:0] mem_addr_i, mem_data_i;
  logic [3:0]  mem_sel_i;
  logic [2:0]  mem_size_i;
  logic        mem_signed_i;
  logic        wf, rf, wf2, rf2;
  logic [31:0] data_o, data_o2;
  int          checks = 0;
  int          errors = 0;

  mem_sram_bridge_if #(.DATA_W(32), .ADDR_W(32)) bus1 ();
  mem_sram_bridge_if #(.DATA_W(32), .ADDR_W(32)) bus2 ();

  mem_sram_bridge #(.DATA_W(32), .ADDR_W(32), .MAX_OUTST(4)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .enable(enable), .we(we),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_sel_i(mem_sel_i),
    .mem_size_i(mem_size_i), .mem_signed_i(mem_signed_i),
    .mem_write_finish(wf), .mem_read_finish(rf), .mem_data_o(data_o), .bus(bus1)
  );

  mem_sram_bridge #(.DATA_W(32), .ADDR_W(32), .MAX_OUTST(2)) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush2), .enable(enable2), .we(we),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_sel_i(mem_sel_i),
    .mem_size_i(mem_size_i), .mem_signed_i(mem_signed_i),
    .mem_write_finish(wf2), .mem_read_finish(rf2), .mem_data_o(data_o2), .bus(bus2)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Zero-extra-wait handshake on bus1: addr_ok in ADDR, one idle DATA cycle, then data_ok.
  task automatic run_xact(input string tag, input logic w, input logic [31:0] a,
                          input logic [2:0] sz, input logic sg, input logic [31:0] rd);
    enable = 1'b1; we = w; mem_addr_i = a; mem_size_i = sz; mem_signed_i = sg;
    cyc();
    chk({tag, "_req_on"}, bus1.req, 1);
    bus1.addr_ok = 1'b1;
    cyc();
    bus1.addr_ok = 1'b0;
    chk({tag, "_req_off"}, bus1.req, 0);
    cyc();
    bus1.data_ok = 1'b1; bus1.rdata = rd;
    cyc();
    bus1.data_ok = 1'b0;
    chk({tag, "_fin"}, w ? wf : rf, 1);
    chk({tag, "_other_fin"}, w ? rf : wf, 0);
    enable = 1'b0;
    cyc();
    chk({tag, "_pulse_end"}, {wf, rf}, 0);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; enable = 1'b0; we = 1'b0;
    flush2 = 1'b0; enable2 = 1'b0;
    mem_addr_i = '0; mem_data_i = 32'h1234_5678; mem_sel_i = 4'hF;
    mem_size_i = 3'd2; mem_signed_i = 1'b0;
    bus1.addr_ok = 1'b0; bus1.data_ok = 1'b0; bus1.rdata = '0;
    bus2.addr_ok = 1'b0; bus2.data_ok = 1'b0; bus2.rdata = '0;
    repeat (3) cyc();
    chk("rst_req", bus1.req, 0);
    chk("rst_fin", {wf, rf}, 0);
    chk("rst_data", data_o, 0);
    rst = 1'b1;
    cyc();

    // Combinational pass-through of request fields
    we = 1'b1; mem_addr_i = 32'hDEAD_BEE0; mem_data_i = 32'hCAFE_F00D;
    mem_sel_i = 4'b0101; mem_size_i = 3'd1;
    #1;
    chk("pass_fields", {bus1.wr, bus1.addr, bus1.wdata, bus1.select, bus1.size},
        {1'b1, 32'hDEAD_BEE0, 32'hCAFE_F00D, 4'b0101, 3'd1});
    cyc();

    run_xact("ld_word", 1'b0, 32'h100, 3'd2, 1'b0, 32'h8899_AABB);
    chk("ld_word_data", data_o, 32'h8899_AABB);
    run_xact("ld_byte_s", 1'b0, 32'h103, 3'd0, 1'b1, 32'h8011_2233);
    chk("ld_byte_s_data", data_o, 32'hFFFF_FF80);
    run_xact("ld_byte_u", 1'b0, 32'h103, 3'd0, 1'b0, 32'h8011_2233);
    chk("ld_byte_u_data", data_o, 32'h0000_0080);
    run_xact("ld_half_u", 1'b0, 32'h102, 3'd1, 1'b0, 32'hBEEF_1234);
    chk("ld_half_u_data", data_o, 32'h0000_BEEF);
    run_xact("ld_half_s", 1'b0, 32'h102, 3'd1, 1'b1, 32'hBEEF_1234);
    chk("ld_half_s_data", data_o, 32'hFFFF_BEEF);
    run_xact("st_word", 1'b1, 32'h180, 3'd2, 1'b0, 32'h5A5A_5A5A);
    chk("st_keeps_data", data_o, 32'hFFFF_BEEF);

    // Flush after addr_ok, before data_ok; next store must skip the stale response
    enable = 1'b1; we = 1'b0; mem_addr_i = 32'h300; mem_size_i = 3'd2;
    cyc();
    bus1.addr_ok = 1'b1;
    cyc();
    bus1.addr_ok = 1'b0; flush = 1'b1;
    cyc();
    flush = 1'b0; we = 1'b1; mem_addr_i = 32'h200;
    chk("flushed_no_fin", {wf, rf}, 0);
    cyc();
    chk("st200_req", {bus1.req, bus1.addr}, {1'b1, 32'h200});
    bus1.addr_ok = 1'b1;
    cyc();
    bus1.addr_ok = 1'b0; bus1.data_ok = 1'b1; bus1.rdata = 32'h0BAD_0BAD;
    cyc();
    bus1.data_ok = 1'b0;
    chk("st200_stale_rsp", {wf, rf}, 0);
    bus1.data_ok = 1'b1;
    cyc();
    bus1.data_ok = 1'b0;
    chk("st200_fin", {wf, rf}, 2'b10);
    enable = 1'b0;
    cyc();
    chk("st200_pulse_end", {wf, rf}, 0);
    chk("st200_data_kept", data_o, 32'hFFFF_BEEF);

    // Same-cycle addr_ok and flush
    enable = 1'b1; we = 1'b0; mem_addr_i = 32'h140; mem_size_i = 3'd2; mem_signed_i = 1'b0;
    cyc();
    bus1.addr_ok = 1'b1; flush = 1'b1;
    cyc();
    bus1.addr_ok = 1'b0; flush = 1'b0; mem_addr_i = 32'h144;
    chk("af_req_drop", {bus1.req, wf, rf}, 0);
    cyc();
    chk("af_reissue", bus1.req, 1);
    bus1.addr_ok = 1'b1;
    cyc();
    bus1.addr_ok = 1'b0; bus1.data_ok = 1'b1; bus1.rdata = 32'hDEAD_DEAD;
    cyc();
    chk("af_stale_rsp", {wf, rf}, 0);
    bus1.rdata = 32'h1122_3344;
    cyc();
    bus1.data_ok = 1'b0;
    chk("af_fin", {wf, rf, data_o}, {2'b01, 32'h1122_3344});
    enable = 1'b0;
    cyc();

    // Flush coinciding with own data_ok: response discarded, nothing left outstanding
    enable = 1'b1; mem_addr_i = 32'h150;
    cyc();
    bus1.addr_ok = 1'b1;
    cyc();
    bus1.addr_ok = 1'b0; flush = 1'b1; bus1.data_ok = 1'b1; bus1.rdata = 32'h5555_5555;
    cyc();
    flush = 1'b0; bus1.data_ok = 1'b0; enable = 1'b0;
    chk("fd_no_fin", {bus1.req, wf, rf, data_o}, {3'b000, 32'h1122_3344});
    cyc();
    run_xact("fd_next", 1'b0, 32'h104, 3'd2, 1'b0, 32'h0BAD_F00D);
    chk("fd_next_data", data_o, 32'h0BAD_F00D);

    // Reset in the middle of DATA
    enable = 1'b1; mem_addr_i = 32'h160;
    cyc();
    bus1.addr_ok = 1'b1;
    cyc();
    bus1.addr_ok = 1'b0; rst = 1'b0;
    cyc();
    chk("midrst_outputs", {bus1.req, wf, rf, data_o}, 0);
    rst = 1'b1; enable = 1'b0;
    cyc();
    run_xact("post_rst_st", 1'b1, 32'h170, 3'd2, 1'b0, 32'h0);
    chk("post_rst_data", data_o, 0);

    // MAX_OUTST=2: one dropped request makes the bridge full until its response returns
    enable2 = 1'b1; we = 1'b0; mem_addr_i = 32'h400; mem_size_i = 3'd2; mem_signed_i = 1'b0;
    cyc();
    chk("m2_req_on", bus2.req, 1);
    bus2.addr_ok = 1'b1;
    cyc();
    bus2.addr_ok = 1'b0; flush2 = 1'b1;
    cyc();
    flush2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("m2_full_hold", bus2.req, 0);
    end
    bus2.data_ok = 1'b1; bus2.rdata = 32'hFFFF_FFFF;
    cyc();
    bus2.data_ok = 1'b0;
    chk("m2_still_idle", {bus2.req, wf2, rf2}, 0);
    cyc();
    chk("m2_reissue", bus2.req, 1);
    bus2.addr_ok = 1'b1;
    cyc();
    bus2.addr_ok = 1'b0; bus2.data_ok = 1'b1; bus2.rdata = 32'hA5A5_0F0F;
    cyc();
    bus2.data_ok = 1'b0;
    chk("m2_fin", {wf2, rf2, data_o2}, {2'b01, 32'hA5A5_0F0F});
    enable2 = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
